seg7_blink_display: RTL and testbench
=====================================

Name: seg7_blink_display

Overview:
- Eight-digit, two-group multiplexed seven-segment display driver for the timer front panel.
- Takes four 8-bit binary fields (hour, min, sec, centisecond). Each field is converted to two BCD digits, then each digit to a segment pattern.
- Both 4-digit groups are scanned in parallel, with per-digit decimal points and per-digit blink.
- Sits between the timer datapath and the board display pins.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); minimum 2.
- BLINK_DIV, 25000000, clk cycles per blink half-period (2 Hz blink at 100 MHz); minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- val3  in  8  binary field for digits 7..6 (hour)
- val2  in  8  binary field for digits 5..4 (min)
- val1  in  8  binary field for digits 3..2 (sec)
- val0  in  8  binary field for digits 1..0 (centisecond)
- dp  in  8  decimal-point enable per digit, bit i = digit i
- star  in  8  blink mask per digit, bit i = digit i
- blink_all  in  1  1 = all digits blink regardless of star
- a_to_g1  out  7  group-1 segments (digits 7..4), active high, bit0=a .. bit6=g
- an1  out  4  group-1 digit select, one-hot, active high, an1[3]=digit 7
- dp1  out  1  group-1 decimal point, active high
- a_to_g2  out  7  group-2 segments (digits 3..0), same encoding
- an2  out  4  group-2 digit select, an2[3]=digit 3, an2[0]=digit 0
- dp2  out  1  group-2 decimal point

Behaviour:
- Binary to BCD (combinational): tens = (v/10)%10, ones = v%10. Values 100..255 drop the hundreds digit (e.g. 137 shows "37").
- BCD to segments (combinational), hex value of a_to_g for 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Any nibble >9 gives 00 (blank).
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1. At wrap, digit index k (2 bits) increments mod 4.
  - Both groups show their digit k simultaneously: group 1 shows digit 4+k, group 2 shows digit k.
  - an1 = an2 = one-hot(k).
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1. At wrap, blink_phase toggles.
  - blink_phase = 1 means visible.
- Blanking: digit i is blanked when blink_phase==0 and (star[i] | blink_all). A blanked digit outputs segments = 0 and dp = 0; its an bit stays asserted.
- Decimal point: dp1 = dp[4+k] and dp2 = dp[k], gated by the blanking rule.
- Output timing:
  - All outputs are registered.
  - Inputs sampled in cycle n appear on the outputs at cycle n+1.
  - A change of k at the wrap appears on an, segments and dp in the same next cycle, so an and segment data never mismatch.
- Reset (rst_n=0 at a clk edge):
  - scan_cnt=0, k=0, blink_cnt=0, blink_phase=1.
  - Every output is 0 while reset is held.
  - First cycle after release: an1 = an2 = 4'b0001, showing digits 4 and 0.
- Reset asserted mid-scan or mid-blink returns to the reset state on the next edge, with no residual phase.
- Changes to val/dp/star take effect on the next clock, independent of the scan position.

Decomposition:
- Shared package seg7_pkg holds:
  - the 10-entry segment lookup constant;
  - the blank pattern constant 7'h00;
  - digit-index width localparam (2).
- One natural sub-module, bin2bcd8: 8-bit binary in, 8-bit packed BCD out {tens, ones}, purely combinational. Instantiate four times.
- Segment lookup, scan and blink logic stay in the top module.

Test Plan:
- Reset and scan (SCAN_DIV=4, BLINK_DIV=1000):
  - Stimulus: hold rst_n=0 for 3 cycles.
  - Response: all outputs 0. After release, an1 = an2 = 0001, then 0010 after 4 cycles, 0100, 1000, then back to 0001 every 16 cycles.
- Conversion (val3=12, val2=34, val1=56, val0=78, star=0):
  - In slot k=0: a_to_g1 = 66 ("4") and a_to_g2 = 7F ("8").
  - In slot k=3: a_to_g1 = 06 ("1") and a_to_g2 = 6D ("5").
- Edges (val0=0, then 99, then 255):
  - val0=0: digits 1 and 0 show 3F 3F.
  - val0=99: 6F 6F.
  - val0=255: 6D 6D ("55").
- Decimal point (dp=8'b01010100):
  - dp2=1 only in slot k=2.
  - dp1=1 in slots k=0 and k=2.
- Blink (BLINK_DIV=8, star=8'b00001100, blink_all=0):
  - Digits 3 and 2 read 00 during phase-0 windows of 8 cycles; other digits are unaffected.
  - With blink_all=1, every digit's segments and dp are 0 in phase 0.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 for 1 cycle while k=2 and blink_phase=0.
  - Response: after release, an = 0001 and digits are visible (phase 1).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display driver: segment lookup,
// blank pattern and digit-index width.
package seg7_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry n is the a..g pattern for decimal digit n (bit0 = a, bit6 = g).
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    if (nib > 4'd9) return SEG_BLANK;
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_blink_display_bin2bcd8.sv
// Combinational 8-bit binary to two-digit packed BCD {tens, ones}.
// Hundreds are dropped, so 137 converts to 8'h37.
module bin2bcd8
  import seg7_pkg::*;
(
  input  logic [7:0] i_bin,
  output logic [7:0] o_bcd
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  assign w_tens = 4'((i_bin / 8'd10) % 8'd10);
  assign w_ones = 4'(i_bin % 8'd10);
  assign o_bcd  = {w_tens, w_ones};

endmodule

// File: rtl/seg7_blink_display.sv
// Eight-digit, two-group multiplexed seven-segment driver with per-digit
// decimal points and blink; both 4-digit groups scan the same slot in parallel.
module seg7_blink_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val3,
  input  logic [7:0] val2,
  input  logic [7:0] val1,
  input  logic [7:0] val0,
  input  logic [7:0] dp,
  input  logic [7:0] star,
  input  logic       blink_all,
  output logic [6:0] a_to_g1,
  output logic [3:0] an1,
  output logic       dp1,
  output logic [6:0] a_to_g2,
  output logic [3:0] an2,
  output logic       dp2
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [DIGIT_W-1:0] r_k;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  logic [6:0] r_seg1, r_seg2;
  logic [3:0] r_an1, r_an2;
  logic       r_dp1, r_dp2;

  logic [7:0] w_bcd3, w_bcd2, w_bcd1, w_bcd0;
  logic [3:0] w_nib1, w_nib2;
  logic [2:0] w_idx1, w_idx2;
  logic       w_blank1, w_blank2;
  logic       w_scan_wrap, w_blink_wrap;
  logic [3:0] w_an;

  bin2bcd8 u_bcd3 (.i_bin(val3), .o_bcd(w_bcd3));
  bin2bcd8 u_bcd2 (.i_bin(val2), .o_bcd(w_bcd2));
  bin2bcd8 u_bcd1 (.i_bin(val1), .o_bcd(w_bcd1));
  bin2bcd8 u_bcd0 (.i_bin(val0), .o_bcd(w_bcd0));

  // Group 1 shows digit 4+k, group 2 shows digit k; odd digits are tens.
  always_comb begin
    w_nib1 = w_bcd2[3:0];
    w_nib2 = w_bcd0[3:0];
    case (r_k)
      2'd0: begin w_nib1 = w_bcd2[3:0]; w_nib2 = w_bcd0[3:0]; end
      2'd1: begin w_nib1 = w_bcd2[7:4]; w_nib2 = w_bcd0[7:4]; end
      2'd2: begin w_nib1 = w_bcd3[3:0]; w_nib2 = w_bcd1[3:0]; end
      default: begin w_nib1 = w_bcd3[7:4]; w_nib2 = w_bcd1[7:4]; end
    endcase
  end

  assign w_idx1   = {1'b1, r_k};
  assign w_idx2   = {1'b0, r_k};
  assign w_blank1 = ~r_blink_phase & (star[w_idx1] | blink_all);
  assign w_blank2 = ~r_blink_phase & (star[w_idx2] | blink_all);
  assign w_an     = 4'b0001 << r_k;

  assign w_scan_wrap  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));

  // Outputs are built from the same r_k sample as an, so select and
  // segment data always change together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt    <= '0;
      r_k           <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_seg1        <= '0;
      r_seg2        <= '0;
      r_an1         <= '0;
      r_an2         <= '0;
      r_dp1         <= 1'b0;
      r_dp2         <= 1'b0;
    end else begin
      if (w_scan_wrap) begin
        r_scan_cnt <= '0;
        r_k        <= r_k + DIGIT_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end

      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end

      r_an1  <= w_an;
      r_an2  <= w_an;
      r_seg1 <= w_blank1 ? SEG_BLANK : seg_encode(w_nib1);
      r_seg2 <= w_blank2 ? SEG_BLANK : seg_encode(w_nib2);
      r_dp1  <= ~w_blank1 & dp[w_idx1];
      r_dp2  <= ~w_blank2 & dp[w_idx2];
    end
  end

  assign a_to_g1 = r_seg1;
  assign an1     = r_an1;
  assign dp1     = r_dp1;
  assign a_to_g2 = r_seg2;
  assign an2     = r_an2;
  assign dp2     = r_dp2;

endmodule

// File: tb/tb_seg7_blink_display.sv
// Scoreboard bench for seg7_blink_display: a driver pushes the expected
// output word for every clock edge, a monitor pops and compares after it.
module tb_seg7_blink_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] val3, val2, val1, val0, dp, star;
  logic       blink_all;
  logic [6:0] a_to_g1, a_to_g2;
  logic [3:0] an1, an2;
  logic       dp1, dp2;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  seg7_blink_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .rst_n(rst_n),
    .val3(val3), .val2(val2), .val1(val1), .val0(val0),
    .dp(dp), .star(star), .blink_all(blink_all),
    .a_to_g1(a_to_g1), .an1(an1), .dp1(dp1),
    .a_to_g2(a_to_g2), .an2(an2), .dp2(dp2)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Decimal digit i of the display: even digits are ones, odd digits tens.
  function automatic int digit_of(input int i);
    int v;
    case (i / 2)
      0: v = int'(val0);
      1: v = int'(val1);
      2: v = int'(val2);
      default: v = int'(val3);
    endcase
    return (i % 2 == 1) ? (v / 10) % 10 : v % 10;
  endfunction

  // Expected {seg1, an1, dp1, seg2, an2, dp2} for the t-th edge after reset.
  function automatic logic [23:0] model(input int t);
    int k;
    bit vis;
    logic [6:0] s1, s2;
    logic d1, d2, b1, b2;
    logic [3:0] an;
    k   = (t / SCAN) % 4;
    vis = ((t / BLINK) % 2) == 0;
    b1  = !vis && (star[4 + k] || blink_all);
    b2  = !vis && (star[k] || blink_all);
    s1  = b1 ? 7'h00 : seg_of(digit_of(4 + k));
    s2  = b2 ? 7'h00 : seg_of(digit_of(k));
    d1  = b1 ? 1'b0 : dp[4 + k];
    d2  = b2 ? 1'b0 : dp[k];
    an  = 4'(1 << k);
    return {s1, an, d1, s2, an, d2};
  endfunction

  // Monitor: every output cycle is compared against the queued expectation.
  initial begin
    int cyc = 0;
    logic [23:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {a_to_g1, an1, dp1, a_to_g2, an2, dp2};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL outputs cyc=%0d got seg1=%h an1=%b dp1=%b seg2=%h an2=%b dp2=%b want seg1=%h an1=%b dp1=%b seg2=%h an2=%b dp2=%b",
                   cyc, got[23:17], got[16:13], got[12], got[11:5], got[4:1], got[0],
                   want[23:17], want[16:13], want[12], want[11:5], want[4:1], want[0]);
        end
        cyc++;
      end
    end
  end

  // Driver: set inputs on the falling edge and queue the expected response.
  initial begin
    int t = 0;
    int drain;
    bit mid_done = 0;
    int vals[3] = '{0, 99, 255};
    rst_n = 1'b0; val3 = 8'd0; val2 = 8'd0; val1 = 8'd0; val0 = 8'd0;
    dp = 8'd0; star = 8'd0; blink_all = 1'b0;

    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (c < 3) begin
        rst_n = 1'b0;
      end else if (c < 80) begin
        val3 = 8'd12; val2 = 8'd34; val1 = 8'd56; val0 = 8'd78;
        dp = 8'd0; star = 8'd0; blink_all = 1'b0;
      end else if (c < 180) begin
        val0 = 8'(vals[((c - 80) / 32) % 3]);
        dp   = 8'b01010100;
      end else if (c < 300) begin
        star = 8'b00001100;
        dp   = 8'($urandom);
        val3 = 8'($urandom); val2 = 8'($urandom);
        val1 = 8'($urandom); val0 = 8'($urandom);
        if (!mid_done && c > 200 && (t % 16) == 9) begin
          rst_n    = 1'b0;
          mid_done = 1;
        end
      end else if (c < 400) begin
        blink_all = 1'b1;
        dp = 8'hFF;
        star = 8'($urandom);
        val3 = 8'($urandom); val2 = 8'($urandom);
        val1 = 8'($urandom); val0 = 8'($urandom);
      end else begin
        blink_all = 1'($urandom_range(0, 3) == 0);
        dp = 8'($urandom); star = 8'($urandom);
        val3 = 8'($urandom); val2 = 8'($urandom);
        val1 = 8'($urandom); val0 = 8'($urandom);
        if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
      end

      if (!rst_n) begin
        exp_q.push_back(24'd0);
        t = 0;
      end else begin
        exp_q.push_back(model(t));
        t++;
      end
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
